// File: rtl/tridiag_det_loader.sv
// Stream-to-register-map feeder for the tridiagonal determinant core: loads a frame, runs the core, returns the result.
// Optional poll timeout is enabled by defining TRIDIAG_LOADER_TIMEOUT_EN.
module tridiag_det_loader #(
   parameter int N              = 16,
   parameter int WIDTH          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_det,
   output logic [1:0]              out_err,
   output logic                    busy,
   output logic                    core_we,
   output logic [7:0]              core_addr,
   output logic [15:0]             core_wdata,
   input  logic [31:0]             core_rdata
);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_LOAD, S_FILL, S_START, S_GAP, S_POLL, S_READ, S_ACK, S_OUT
   } state_t;

   localparam logic [5:0] K_LAST = 6'(3*N-3);
   localparam logic [7:0] A_START = 8'h00;
   localparam logic [7:0] A_STAT  = 8'h01;
   localparam logic [7:0] A_ACK   = 8'h02;
   localparam logic [7:0] A_DET   = 8'h40;

   // Beat order is b[0..N-1], a[0..N-2], c[0..N-2].
   function automatic logic [7:0] beat_addr(input logic [5:0] k);
      logic [7:0] kk;
      kk = {2'b00, k};
      if (kk < 8'(N))
         return 8'h20 + kk;
      else if (kk < 8'(2*N-1))
         return 8'h10 + kk - 8'(N);
      else
         return 8'h30 + kk - 8'(2*N-1);
   endfunction

   function automatic logic [15:0] sext16(input logic signed [WIDTH-1:0] d);
      return 16'(d);
   endfunction

   state_t      r_state, w_state_nxt;
   logic [5:0]  r_k;
   logic        r_ferr;
   logic [31:0] r_det;
   logic        r_we;
   logic [7:0]  r_addr;
   logic [15:0] r_wdata;
   logic        w_acc;
   logic        w_to;
   logic        w_timeout;

`ifdef TRIDIAG_LOADER_TIMEOUT_EN
   logic [15:0] r_pcnt;
   logic        r_to;
   assign w_to      = r_to;
   assign w_timeout = (r_pcnt == 16'(TIMEOUT_CYCLES - 1));
`else
   assign w_to      = 1'b0;
   assign w_timeout = 1'b0;
`endif

   assign in_ready   = (r_state == S_IDLE) || (r_state == S_LOAD);
   assign w_acc      = in_valid && in_ready;
   assign out_valid  = (r_state == S_OUT);
   assign busy       = (r_state != S_IDLE);
   assign out_det    = r_det;
   assign out_err    = {w_to, r_ferr};
   assign core_we    = r_we;
   assign core_addr  = r_addr;
   assign core_wdata = r_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_INIT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:  w_state_nxt = S_IDLE;
         S_IDLE, S_LOAD: begin
            if (w_acc) begin
               if (r_k == K_LAST) w_state_nxt = S_START;
               else if (in_last)  w_state_nxt = S_FILL;
               else               w_state_nxt = S_LOAD;
            end
         end
         S_FILL:  if (r_k == K_LAST) w_state_nxt = S_START;
         S_START: w_state_nxt = S_GAP;
         S_GAP:   w_state_nxt = S_POLL;
         S_POLL: begin
            if (core_rdata[0]) w_state_nxt = S_READ;
            else if (w_timeout) w_state_nxt = S_ACK;
         end
         S_READ:  w_state_nxt = S_ACK;
         S_ACK:   w_state_nxt = S_OUT;
         S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_INIT;
      endcase
   end

   // Core commands are registered: whatever is decided here reaches the core next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k     <= '0;
         r_ferr  <= 1'b0;
         r_det   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
`ifdef TRIDIAG_LOADER_TIMEOUT_EN
         r_pcnt  <= '0;
         r_to    <= 1'b0;
`endif
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_INIT, S_ACK: begin
               r_we    <= 1'b1;
               r_addr  <= A_ACK;
               r_wdata <= 16'd1;
            end
            S_IDLE, S_LOAD: begin
               if (w_acc) begin
                  r_we    <= 1'b1;
                  r_addr  <= beat_addr(r_k);
                  r_wdata <= sext16(in_data);
                  if (r_k == K_LAST) begin
                     if (!in_last) r_ferr <= 1'b1;
                  end else begin
                     r_k <= r_k + 6'd1;
                     if (in_last) r_ferr <= 1'b1;
                  end
               end
            end
            S_FILL: begin
               r_we    <= 1'b1;
               r_addr  <= beat_addr(r_k);
               r_wdata <= '0;
               if (r_k != K_LAST) r_k <= r_k + 6'd1;
            end
            S_START: begin
               r_we    <= 1'b1;
               r_addr  <= A_START;
               r_wdata <= 16'd1;
            end
            S_GAP: begin
               r_addr <= A_STAT;
`ifdef TRIDIAG_LOADER_TIMEOUT_EN
               r_pcnt <= '0;
`endif
            end
            S_POLL: begin
               if (core_rdata[0]) begin
                  r_addr <= A_DET;
               end else begin
`ifdef TRIDIAG_LOADER_TIMEOUT_EN
                  if (w_timeout) begin
                     r_det <= '0;
                     r_to  <= 1'b1;
                  end else begin
                     r_pcnt <= r_pcnt + 16'd1;
                  end
`endif
               end
            end
            S_READ: r_det <= core_rdata;
            S_OUT: begin
               if (out_ready) begin
                  r_k    <= '0;
                  r_ferr <= 1'b0;
`ifdef TRIDIAG_LOADER_TIMEOUT_EN
                  r_to   <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tridiag_det_loader.sv
// Directed bench for tridiag_det_loader with a behavioural core stub (N=4).
module tb_tridiag_det_loader;

   localparam int N = 4;
   localparam int NB = 3*N-2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] in_data = '0;
   logic               in_last = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [31:0]        out_det;
   logic [1:0]         out_err;
   logic               busy;
   logic               core_we;
   logic [7:0]         core_addr;
   logic [15:0]        core_wdata;
   logic [31:0]        core_rdata;

   always #5 clk = ~clk;

   tridiag_det_loader #(.N(N), .WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_det(out_det), .out_err(out_err),
      .busy(busy), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata)
   );

   // Core stub: register file, start/done/ack handshake, fixed calc delay.
   logic signed [15:0] ra [16];
   logic signed [15:0] rb [16];
   logic signed [15:0] rc [16];
   logic        done = 1'b0;
   logic [31:0] det = '0;
   int          cnt = 0;
   bit          hang = 1'b0;
   logic [23:0] wlog [$];

   function automatic logic [31:0] calc();
      longint f0, f1, f2;
      f0 = 1;
      f1 = longint'(rb[0]);
      for (int k = 2; k <= N; k++) begin
         f2 = longint'(rb[k-1]) * f1 - longint'(ra[k-2]) * longint'(rc[k-2]) * f0;
         f0 = f1;
         f1 = f2;
      end
      return f1[31:0];
   endfunction

   always @(posedge clk) begin
      if (cnt > 0) begin
         cnt <= cnt - 1;
         if (cnt == 1) done <= 1'b1;
      end
      if (core_we) begin
         wlog.push_back({core_addr, core_wdata});
         if (core_addr == 8'h00 && core_wdata[0]) begin
            det  <= calc();
            done <= 1'b0;
            if (!hang) cnt <= 4;
         end else if (core_addr == 8'h02) begin
            done <= 1'b0;
         end else if (core_addr >= 8'h10 && core_addr < 8'h20) begin
            ra[core_addr[3:0]] <= core_wdata;
         end else if (core_addr >= 8'h20 && core_addr < 8'h30) begin
            rb[core_addr[3:0]] <= core_wdata;
         end else if (core_addr >= 8'h30 && core_addr < 8'h40) begin
            rc[core_addr[3:0]] <= core_wdata;
         end
      end
   end

   assign core_rdata = (core_addr == 8'h01) ? {31'b0, done} :
                       (core_addr == 8'h40) ? det : 32'h0;

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [15:0] ent [NB];
      int          nb;
      int          lastb;
      logic [31:0] det;
      logic [1:0]  err;
   } vec_t;

   vec_t vecs [6];

   task automatic send_beat(input logic [15:0] d, input bit last, output bit ok);
      int w;
      w = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      ok = in_ready;
      if (ok) @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input vec_t v, input int nbeats);
      bit ok;
      for (int i = 0; i < nbeats; i++) begin
         send_beat(v.ent[i], (i == v.lastb), ok);
         if (!ok) begin
            chk({v.name, "_beat_accept"}, 0, 1);
            break;
         end
      end
   endtask

   task automatic wait_result(input string name, output bit ok);
      int w;
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 300) begin
         @(negedge clk);
         w++;
      end
      ok = out_valid;
      if (!ok) chk({name, "_result_wait"}, 0, 1);
   endtask

   logic [61:0] rst_vals;
   assign rst_vals = {in_ready, out_valid, out_det, out_err, busy, core_we, core_addr, core_wdata};
   localparam logic [61:0] RST_EXP = {1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 8'h00, 16'h0000};

   initial begin
      bit ok;
      bit good;
      logic [7:0] exp_addr [12];
      logic [31:0] held;

      vecs[0] = '{name: "unit_b",  ent: '{16'd1,16'd1,16'd1,16'd1, 16'd0,16'd0,16'd0, 16'd0,16'd0,16'd0},
                  nb: 10, lastb: 9, det: 32'd1, err: 2'b00};
      vecs[1] = '{name: "b2_ac1",  ent: '{16'd2,16'd2,16'd2,16'd2, 16'd1,16'd1,16'd1, 16'd1,16'd1,16'd1},
                  nb: 10, lastb: 9, det: 32'd5, err: 2'b00};
      vecs[2] = '{name: "bm2_ac1", ent: '{16'hFFFE,16'hFFFE,16'hFFFE,16'hFFFE, 16'd1,16'd1,16'd1, 16'd1,16'd1,16'd1},
                  nb: 10, lastb: 9, det: 32'd5, err: 2'b00};
      vecs[3] = '{name: "early_last", ent: '{16'd3,16'd3,16'd3,16'd0, 16'd0,16'd0,16'd0, 16'd0,16'd0,16'd0},
                  nb: 3, lastb: 2, det: 32'd0, err: 2'b01};
      vecs[4] = '{name: "no_last", ent: '{16'd1,16'd2,16'd3,16'd4, 16'd0,16'd0,16'd0, 16'd0,16'd0,16'd0},
                  nb: 10, lastb: -1, det: 32'd24, err: 2'b01};
      vecs[5] = '{name: "neg_det", ent: '{16'd3,16'd1,16'd2,16'd1, 16'd1,16'd1,16'd1, 16'd2,16'd2,16'd2},
                  nb: 10, lastb: 9, det: 32'hFFFF_FFFA, err: 2'b00};
      exp_addr = '{8'h20,8'h21,8'h22,8'h23, 8'h10,8'h11,8'h12, 8'h30,8'h31,8'h32, 8'h00,8'h02};

      // Reset state, then the INIT ack as the first command.
      repeat (2) @(negedge clk);
      chk("reset_values", 64'(rst_vals), 64'(RST_EXP));
      rst_n = 1'b1;
      @(negedge clk);
      chk("init_ack", {core_we, core_addr}, {1'b1, 8'h02});
      @(negedge clk);
      chk("idle_after_init", {busy, in_ready}, {1'b0, 1'b1});

      for (int v = 0; v < 6; v++) begin
         wlog.delete();
         out_ready = 1'b1;
         send_frame(vecs[v], vecs[v].nb);
         wait_result(vecs[v].name, ok);
         if (ok) begin
            chk({vecs[v].name, "_det"}, out_det, vecs[v].det);
            chk({vecs[v].name, "_err"}, out_err, vecs[v].err);
            @(negedge clk);
            chk({vecs[v].name, "_idle"}, {busy, out_valid}, {1'b0, 1'b0});
         end
         if (v == 0) begin
            good = (wlog.size() == 12);
            for (int i = 0; i < 12 && good; i++)
               if (wlog[i][23:16] != exp_addr[i]) good = 1'b0;
            if (good && wlog[10][15:0] != 16'd1) good = 1'b0;
            chk("write_sequence", good, 1'b1);
         end
         if (v == 3) begin
            good = (wlog.size() == 12);
            for (int i = 0; i < 12 && good; i++)
               if (wlog[i][23:16] != exp_addr[i]) good = 1'b0;
            for (int i = 3; i < 10 && good; i++)
               if (wlog[i][15:0] != 16'd0) good = 1'b0;
            chk("fill_zero_writes", good, 1'b1);
         end
      end

      // Output backpressure: result held for 10 cycles.
      out_ready = 1'b0;
      send_frame(vecs[1], vecs[1].nb);
      wait_result("hold", ok);
      if (ok) begin
         held = out_det;
         good = 1'b1;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(out_valid && out_det == held && !in_ready && busy)) good = 1'b0;
         end
         chk("hold_stable", {good, held}, {1'b1, 32'd5});
         out_ready = 1'b1;
         @(negedge clk);
         chk("hold_release", {busy, in_ready, out_valid}, {1'b0, 1'b1, 1'b0});
      end

      // Async reset mid-LOAD at beat 5, then a clean frame.
      send_frame(vecs[2], 5);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[2].ent[5];
      #2;
      rst_n = 1'b0;
      #1;
      chk("midload_reset_values", 64'(rst_vals), 64'(RST_EXP));
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_reack", {core_we, core_addr}, {1'b1, 8'h02});
      send_frame(vecs[1], vecs[1].nb);
      wait_result("post_reset", ok);
      if (ok) chk("post_reset_det", {out_err, out_det}, {2'b00, 32'd5});
      @(negedge clk);

`ifdef TRIDIAG_LOADER_TIMEOUT_EN
      hang = 1'b1;
      wlog.delete();
      send_frame(vecs[0], vecs[0].nb);
      wait_result("timeout", ok);
      if (ok) begin
         chk("timeout_result", {out_err, out_det}, {2'b10, 32'd0});
         chk("timeout_ack", (wlog.size() > 0) ? wlog[wlog.size()-1][23:16] : 8'hFF, 8'h02);
      end
      @(negedge clk);
      hang = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
